// File: rtl/barrel_rotator_scheduler.sv
// Round-robin scheduler sharing one right barrel rotator among several requesters.
// Optional per-requester left rotation: define BARREL_ROTATOR_SCHEDULER_DIRECTION_EN.
module barrel_rotator_scheduler #(
    parameter int DATA_WIDTH     = 8,
    parameter int REQUESTERS     = 4,
    parameter int ROTATION_WIDTH = $clog2(DATA_WIDTH),
    parameter int INDEX_WIDTH    = $clog2(REQUESTERS)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [REQUESTERS-1:0]                request_valid,
    output logic [REQUESTERS-1:0]                request_ready,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]     request_data,
    input  logic [REQUESTERS*ROTATION_WIDTH-1:0] request_rotation,
`ifdef BARREL_ROTATOR_SCHEDULER_DIRECTION_EN
    input  logic [REQUESTERS-1:0]                request_left,
`endif
    output logic                                 response_valid,
    input  logic                                 response_ready,
    output logic [DATA_WIDTH-1:0]                response_data,
    output logic [INDEX_WIDTH-1:0]               response_requester
);

    logic                      valid_q;
    logic                      valid_d;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     data_d;
    logic [INDEX_WIDTH-1:0]    requester_q;
    logic [INDEX_WIDTH-1:0]    requester_d;
    logic [INDEX_WIDTH-1:0]    pointer_q;
    logic [INDEX_WIDTH-1:0]    pointer_d;

    logic                      accept;
    logic                      transfer;
    logic                      grant_found;
    logic [INDEX_WIDTH-1:0]    grant_idx;
    logic [INDEX_WIDTH-1:0]    cand;
    logic [REQUESTERS-1:0]     grant_oh;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [ROTATION_WIDTH-1:0] sel_rot;
    logic                      sel_left;
    logic [ROTATION_WIDTH-1:0] rot_red;
    logic [ROTATION_WIDTH-1:0] rot_amt;
    logic [DATA_WIDTH-1:0]     stage_v;
    logic [DATA_WIDTH-1:0]     shift_v;

    assign accept   = ~valid_q | response_ready;
    assign transfer = grant_found & accept;

    // Round-robin search starting at the priority pointer
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < REQUESTERS; off++) begin
            cand = INDEX_WIDTH'((int'(pointer_q) + off) % REQUESTERS);
            if (!grant_found && request_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot grant, gated by output-register availability and reset
    always_comb begin
        grant_oh = '0;
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
        request_ready = grant_oh & {REQUESTERS{accept & ~reset}};
    end

    // Operand mux: pick the granted requester's word, rotation and direction
    always_comb begin
        sel_data = '0;
        sel_rot  = '0;
        sel_left = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_idx == INDEX_WIDTH'(i)) begin
                sel_data = request_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_rot  = request_rotation[i*ROTATION_WIDTH +: ROTATION_WIDTH];
`ifdef BARREL_ROTATOR_SCHEDULER_DIRECTION_EN
                sel_left = request_left[i];
`endif
            end
        end
    end

    // Reduce amount mod DATA_WIDTH (one subtract suffices) and map left to right
    always_comb begin
        rot_red = sel_rot;
        if (int'(sel_rot) >= DATA_WIDTH) begin
            rot_red = sel_rot - ROTATION_WIDTH'(DATA_WIDTH);
        end
        rot_amt = rot_red;
        if (sel_left && (rot_red != '0)) begin
            rot_amt = ROTATION_WIDTH'(DATA_WIDTH) - rot_red;
        end
    end

    // Shared logarithmic right rotator
    always_comb begin
        stage_v = sel_data;
        shift_v = sel_data;
        for (int s = 0; s < ROTATION_WIDTH; s++) begin
            shift_v = stage_v;
            if (rot_amt[s]) begin
                for (int b = 0; b < DATA_WIDTH; b++) begin
                    shift_v[b] = stage_v[(b + (1 << s)) % DATA_WIDTH];
                end
            end
            stage_v = shift_v;
        end
    end

    // Next-state for the output register and the priority pointer
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        requester_d = requester_q;
        pointer_d   = pointer_q;
        if (transfer) begin
            valid_d     = 1'b1;
            data_d      = stage_v;
            requester_d = grant_idx;
            if (grant_idx == INDEX_WIDTH'(REQUESTERS - 1)) begin
                pointer_d = '0;
            end else begin
                pointer_d = grant_idx + 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            requester_q <= '0;
            pointer_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            requester_q <= requester_d;
            pointer_q   <= pointer_d;
        end
    end

    assign response_valid     = valid_q;
    assign response_data      = data_q;
    assign response_requester = requester_q;

endmodule

// File: tb/tb_barrel_rotator_scheduler.sv
// Self-checking bench for barrel_rotator_scheduler: vector table plus
// scoreboard queue, with hand sequences for reset and a 6-bit instance.
module tb_barrel_rotator_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  request_valid;
    logic [3:0]  request_ready;
    logic [31:0] request_data;
    logic [11:0] request_rotation;
    logic        response_valid;
    logic        response_ready;
    logic [7:0]  response_data;
    logic [1:0]  response_requester;
`ifdef BARREL_ROTATOR_SCHEDULER_DIRECTION_EN
    logic [3:0]  left_s;
    logic [1:0]  left6;
`endif

    logic [1:0]  v6;
    logic [1:0]  rdy6;
    logic [11:0] d6;
    logic [5:0]  r6;
    logic        rv6;
    logic [5:0]  data6;
    logic [0:0]  req6;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    barrel_rotator_scheduler u_dut (
        .clock              (clock),
        .reset              (reset),
        .request_valid      (request_valid),
        .request_ready      (request_ready),
        .request_data       (request_data),
        .request_rotation   (request_rotation),
`ifdef BARREL_ROTATOR_SCHEDULER_DIRECTION_EN
        .request_left       (left_s),
`endif
        .response_valid     (response_valid),
        .response_ready     (response_ready),
        .response_data      (response_data),
        .response_requester (response_requester)
    );

    barrel_rotator_scheduler #(.DATA_WIDTH(6), .REQUESTERS(2)) u_dut6 (
        .clock              (clock),
        .reset              (reset),
        .request_valid      (v6),
        .request_ready      (rdy6),
        .request_data       (d6),
        .request_rotation   (r6),
`ifdef BARREL_ROTATOR_SCHEDULER_DIRECTION_EN
        .request_left       (left6),
`endif
        .response_valid     (rv6),
        .response_ready     (1'b1),
        .response_data      (data6),
        .response_requester (req6)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] req;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [11:0] r;
        logic        rr;
        logic [3:0]  rdy;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rotation: bit k of result = bit (k+rot) mod w of input
    function automatic logic [7:0] ror_model(input logic [7:0] x, input int rot,
                                             input bit left, input int w);
        int r;
        logic [7:0] y;
        r = rot % w;
        if (left) r = (w - r) % w;
        y = '0;
        for (int k = 0; k < w; k++) y[k] = x[(k + r) % w];
        return y;
    endfunction

    task automatic step(input logic [3:0] v, input logic [31:0] d,
                        input logic [11:0] r, input logic rr,
                        input logic [3:0] exp_rdy, input logic [3:0] lf);
        request_valid    = v;
        request_data     = d;
        request_rotation = r;
        response_ready   = rr;
`ifdef BARREL_ROTATOR_SCHEDULER_DIRECTION_EN
        left_s           = lf;
`endif
        #1;
        chk("ready", 32'(request_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(response_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("resp_data", 32'(response_data), 32'(q[0].d));
            chk("resp_req", 32'(response_requester), 32'(q[0].req));
            if (rr) void'(q.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                q.push_back('{d: ror_model(d[i*8 +: 8], int'(r[i*3 +: 3]),
                                           lf[i], 8),
                              req: 2'(i)});
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 32'h0096_0000, 12'o0100, 1'b1, 4'b0100};
        tbl[1]  = '{4'b0000, 32'h0,         12'o0,    1'b1, 4'b0000};
        tbl[2]  = '{4'b0001, 32'h0000_0081, 12'o0000, 1'b1, 4'b0001};
        tbl[3]  = '{4'b0010, 32'h0000_8100, 12'o0070, 1'b1, 4'b0010};
        tbl[4]  = '{4'b0001, 32'h0000_000F, 12'o0000, 1'b1, 4'b0001};
        tbl[5]  = '{4'b1010, 32'hA500_3C00, 12'o4010, 1'b0, 4'b0000};
        tbl[6]  = '{4'b1010, 32'hA500_3C00, 12'o4010, 1'b0, 4'b0000};
        tbl[7]  = '{4'b1010, 32'hA500_3C00, 12'o4010, 1'b0, 4'b0000};
        tbl[8]  = '{4'b1010, 32'hA500_3C00, 12'o4010, 1'b1, 4'b0010};
        tbl[9]  = '{4'b1000, 32'hA500_0000, 12'o4000, 1'b1, 4'b1000};
        tbl[10] = '{4'b0000, 32'h0,         12'o0,    1'b1, 4'b0000};
        tbl[11] = '{4'b1111, 32'h4433_2211, 12'o0,    1'b1, 4'b0001};
        tbl[12] = '{4'b1111, 32'h4433_2211, 12'o0,    1'b1, 4'b0010};
        tbl[13] = '{4'b1111, 32'h4433_2211, 12'o0,    1'b1, 4'b0100};
        tbl[14] = '{4'b1111, 32'h4433_2211, 12'o0,    1'b1, 4'b1000};
        tbl[15] = '{4'b1111, 32'h4433_2211, 12'o0,    1'b1, 4'b0001};
        tbl[16] = '{4'b0000, 32'h0,         12'o0,    1'b1, 4'b0000};

        reset            = 1'b1;
        request_valid    = 4'hF;
        request_data     = 32'h0;
        request_rotation = 12'h0;
        response_ready   = 1'b1;
        v6               = 2'b00;
        d6               = 12'h0;
        r6               = 6'h0;
`ifdef BARREL_ROTATOR_SCHEDULER_DIRECTION_EN
        left_s           = 4'h0;
        left6            = 2'b00;
`endif
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(response_valid), 32'd0);
        chk("rst_data", 32'(response_data), 32'd0);
        chk("rst_req", 32'(response_requester), 32'd0);
        chk("rst_ready", 32'(request_ready), 32'd0);
        chk("rst_valid6", 32'(rv6), 32'd0);
        reset = 1'b0;

        for (int n = 0; n < 17; n++) begin
            step(tbl[n].v, tbl[n].d, tbl[n].r, tbl[n].rr, tbl[n].rdy, 4'h0);
        end

        // Park the pointer at 3 with a pending result, then reset
        step(4'b0100, 32'h0077_0000, 12'o0, 1'b1, 4'b0100, 4'h0);
        request_valid = 4'hF;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(response_valid), 32'd0);
        chk("midrst_ready", 32'(request_ready), 32'd0);
        chk("midrst_data", 32'(response_data), 32'd0);
        q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(4'b1111, 32'h4433_2211, 12'o0, 1'b1, 4'b0001, 4'h0);
        step(4'b0000, 32'h0, 12'o0, 1'b1, 4'b0000, 4'h0);

        // Non-power-of-two width: rotation 7 reduces to 1
        v6 = 2'b10;
        d6 = {6'h21, 6'h00};
        r6 = {3'd7, 3'd0};
        #1;
        chk("w6_ready", 32'(rdy6), 32'd2);
        @(posedge clock);
        @(negedge clock);
        v6 = 2'b00;
        #1;
        chk("w6_valid", 32'(rv6), 32'd1);
        chk("w6_data", 32'(data6), 32'(ror_model(8'h21, 7, 1'b0, 6)));
        chk("w6_req", 32'(req6), 32'd1);
        @(negedge clock);

`ifdef BARREL_ROTATOR_SCHEDULER_DIRECTION_EN
        step(4'b0100, 32'h0096_0000, 12'o0100, 1'b1, 4'b0100, 4'b0100);
        step(4'b0100, 32'h0096_0000, 12'o0000, 1'b1, 4'b0100, 4'b0100);
        step(4'b0000, 32'h0, 12'o0, 1'b1, 4'b0000, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
